aes_key_sched_seq: RTL and testbench

//  Sequential AES key-schedule control sequencer for AES-128/192/256. On start it steps

---
 rtl/aes_key_sched_seq.sv | 118 +++++++++++
 tb/tb_aes_key_sched_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_seq.sv
// AES-128/192/256 key-schedule control sequencer: emits one control beat per
// expanded-key word (rcon, RotWord/SubWord flags, round/column) over valid/ready.
module aes_key_sched_seq #(
    parameter bit EN_192 = 1'b1,
    parameter bit EN_256 = 1'b1,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       len,
    input  logic             abort,
    input  logic             word_rdy,
    output logic             word_vld,
    output logic [IDX_W-1:0] word_idx,
    output logic [3:0]       rk_idx,
    output logic [1:0]       rk_col,
    output logic [7:0]       rcon,
    output logic             rot_sub,
    output logic             sub_only,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [3:0]       nk;
    logic [IDX_W-1:0] last_idx;
    logic [2:0]       phase;
    logic [7:0]       rcon_reg;

    logic             len_ok;
    logic [3:0]       nk_new;
    logic [5:0]       last_new;
    logic             xfer;
    logic             phase_wrap;

    always_comb begin
        len_ok   = (len == 2'b00) || (len == 2'b01 && EN_192) || (len == 2'b10 && EN_256);
        nk_new   = 4'd4;
        last_new = 6'd43;
        case (len)
            2'b01:   begin nk_new = 4'd6; last_new = 6'd51; end
            2'b10:   begin nk_new = 4'd8; last_new = 6'd59; end
            default: begin nk_new = 4'd4; last_new = 6'd43; end
        endcase
    end

    assign xfer       = word_vld & word_rdy;
    // Phase tracks i mod Nk so no divider is needed.
    assign phase_wrap = ({1'b0, phase} == nk - 4'd1);

    // Beat fields are pure functions of held registers, so they stay stable under stall.
    assign rot_sub  = word_vld && (phase == 3'd0);
    assign sub_only = word_vld && (nk == 4'd8) && (phase == 3'd4);
    assign rcon     = rot_sub ? rcon_reg : 8'h00;
    assign last     = word_vld && (word_idx == last_idx);
    assign rk_idx   = word_idx[5:2];
    assign rk_col   = word_idx[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            nk       <= 4'd0;
            last_idx <= '0;
            word_idx <= '0;
            phase    <= 3'd0;
            rcon_reg <= 8'h01;
            word_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state    <= RUN;
                            nk       <= nk_new;
                            last_idx <= IDX_W'(last_new);
                            word_idx <= IDX_W'(nk_new);
                            phase    <= 3'd0;
                            rcon_reg <= 8'h01;
                            word_vld <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        word_vld <= 1'b0;
                        busy     <= 1'b0;
                    end else if (xfer) begin
                        if (last) begin
                            state    <= IDLE;
                            word_vld <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            phase    <= phase_wrap ? 3'd0 : phase + 3'd1;
                            if (rot_sub)
                                rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Bench for aes_key_sched_seq: beats are checked against a model computed from
// i mod Nk and an rcon table, with random and forced backpressure.
module tb_aes_key_sched_seq;
    logic       clk = 1'b0;
    logic       rst, start, start2, abort, word_rdy;
    logic [1:0] len;

    logic       word_vld, rot_sub, sub_only, last, busy, done, err;
    logic [5:0] word_idx;
    logic [3:0] rk_idx;
    logic [1:0] rk_col;
    logic [7:0] rcon;

    logic       d2_vld, d2_rot_sub, d2_sub_only, d2_last, d2_busy, d2_done, d2_err;
    logic [5:0] d2_idx;
    logic [3:0] d2_rk_idx;
    logic [1:0] d2_rk_col;
    logic [7:0] d2_rcon;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_sched_seq #(.EN_192(1'b1), .EN_256(1'b1), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .word_rdy(word_rdy),
        .word_vld(word_vld), .word_idx(word_idx), .rk_idx(rk_idx), .rk_col(rk_col),
        .rcon(rcon), .rot_sub(rot_sub), .sub_only(sub_only), .last(last),
        .busy(busy), .done(done), .err(err)
    );

    aes_key_sched_seq #(.EN_192(1'b0), .EN_256(1'b1), .IDX_W(6)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .len(len), .abort(abort), .word_rdy(word_rdy),
        .word_vld(d2_vld), .word_idx(d2_idx), .rk_idx(d2_rk_idx), .rk_col(d2_rk_col),
        .rcon(d2_rcon), .rot_sub(d2_rot_sub), .sub_only(d2_sub_only), .last(d2_last),
        .busy(d2_busy), .done(d2_done), .err(d2_err)
    );

    function automatic int nk_of(input logic [1:0] l);
        return (l == 2'b01) ? 6 : (l == 2'b10) ? 8 : 4;
    endfunction

    // Expected {word_idx, rk_idx, rk_col, rcon, rot_sub, sub_only, last, busy} for word i.
    function automatic logic [23:0] model(input int i, input int nk);
        logic [7:0] tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        int   lasti = 4 * (nk + 7) - 1;
        logic rs    = (i % nk) == 0;
        logic so    = (nk == 8) && (i % 8 == 4);
        logic [7:0] rc = rs ? tbl[i / nk - 1] : 8'h00;
        return {6'(i), 4'(i / 4), 2'(i % 4), rc, rs, so, (i == lasti), 1'b1};
    endfunction

    // All tasks enter and leave on a negedge; inputs set there take effect at the next posedge.
    task automatic begin_sched(input logic [1:0] l);
        start = 1'b1; len = l;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (word_vld !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency len=%0d vld=%b busy=%b want 1 1", l, word_vld, busy);
        end
    endtask

    // Steps the schedule, checking every cycle; returns at stop_at (untransferred) or after done.
    task automatic run_beats(input logic [1:0] l, input int stall_pct, input int hold_i,
                             input int stop_at);
        int nk = nk_of(l);
        int lasti = 4 * (nk + 7) - 1;
        int i = nk;
        int held = 0;
        int budget = 2000;
        logic [23:0] got, exp;
        while (i <= lasti) begin
            got = {word_idx, rk_idx, rk_col, rcon, rot_sub, sub_only, last, busy};
            exp = model(i, nk);
            checks++;
            if (word_vld !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL beat len=%0d i=%0d vld=%b got=%h want=%h", l, i, word_vld, got, exp);
            end
            if (i == stop_at) return;
            if (i == hold_i && held < 3) begin
                word_rdy = 1'b0; held++;
            end else begin
                word_rdy = ($urandom_range(99) >= stall_pct);
            end
            if (word_rdy) i++;
            @(negedge clk);
            budget--;
            if (budget == 0) begin
                errors++;
                $display("FAIL timeout len=%0d i=%0d", l, i);
                return;
            end
        end
        word_rdy = 1'b0;
        checks++;
        if (done !== 1'b1 || word_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b vld=%b busy=%b want 1 0 0", done, word_vld, busy);
        end
    endtask

    task automatic check_done_clear();
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_clear done=%b want 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; word_rdy = 1'b0; len = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({word_vld, word_idx, rk_idx, rk_col, rcon, rot_sub, sub_only, last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs vld=%b idx=%0d rcon=%h rs=%b busy=%b want all 0",
                     word_vld, word_idx, rcon, rot_sub, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        begin_sched(2'b00); run_beats(2'b00, 0, -1, -1); check_done_clear();
    endtask

    task automatic test_aes192();
        begin_sched(2'b01); run_beats(2'b01, 0, -1, -1); check_done_clear();
    endtask

    task automatic test_aes256();
        begin_sched(2'b10); run_beats(2'b10, 30, -1, -1); check_done_clear();
    endtask

    task automatic test_backpressure();
        begin_sched(2'b00); run_beats(2'b00, 40, 8, -1); check_done_clear();
    endtask

    task automatic test_back_to_back();
        begin_sched(2'b10); run_beats(2'b10, 20, -1, -1);
        begin_sched(2'b00); run_beats(2'b00, 20, -1, -1); check_done_clear();
    endtask

    task automatic test_abort();
        begin_sched(2'b00);
        run_beats(2'b00, 25, -1, 20);
        abort = 1'b1; word_rdy = 1'b1;
        @(negedge clk);
        abort = 1'b0; word_rdy = 1'b0;
        checks++;
        if (word_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort vld=%b busy=%b done=%b want 0 0 0", word_vld, busy, done);
        end
        check_done_clear();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (word_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle vld=%b busy=%b want 0 0", word_vld, busy);
        end
        begin_sched(2'b00); run_beats(2'b00, 0, -1, -1); check_done_clear();
    endtask

    task automatic test_rst_midrun();
        begin_sched(2'b00);
        run_beats(2'b00, 10, -1, 30);
        rst = 1'b1; word_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0; word_rdy = 1'b0;
        checks++;
        if ({word_vld, word_idx, rk_idx, rk_col, rcon, rot_sub, sub_only, last, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL rst_midrun vld=%b idx=%0d rcon=%h busy=%b done=%b want all 0",
                     word_vld, word_idx, rcon, busy, done);
        end
        check_done_clear();
    endtask

    task automatic test_err();
        start = 1'b1; len = 2'b11;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || word_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_reserved err=%b busy=%b vld=%b want 1 0 0", err, busy, word_vld);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || word_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b vld=%b want 0 0", err, word_vld);
        end
        start2 = 1'b1; len = 2'b01;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if (d2_err !== 1'b1 || d2_busy !== 1'b0 || d2_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_disabled192 err=%b busy=%b vld=%b want 1 0 0", d2_err, d2_busy, d2_vld);
        end
        @(negedge clk);
        checks++;
        if (d2_err !== 1'b0 || d2_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_disabled_clear err=%b vld=%b want 0 0", d2_err, d2_vld);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_rst_midrun();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
